// File: rtl/click_pkg.sv
// Shared types and limits for the click-to-synchronous sink.
package click_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StSettle    = 2'd1,
        StWaitSpace = 2'd2
    } sink_state_t;

endpackage

// File: rtl/click_sync.sv
// Multi-flop synchronizer bringing the asynchronous two-phase req into the clk domain.
module click_sync
    import click_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    localparam int unsigned STAGES =
        (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/click_sink.sv
// Two-phase click receiver: synchronizes req, waits a bundling margin, captures data_in
// into a first-word fall-through FIFO and returns a registered ack toggle.
module click_sink
    import click_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned DEPTH =
        (FIFO_DEPTH < MIN_FIFO_DEPTH) ? MIN_FIFO_DEPTH : FIFO_DEPTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = $clog2(SETTLE_CYCLES + 2);

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(1);
    localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);

    sink_state_t              r_state;
    sink_state_t              w_state_next;
    logic [SC_W-1:0]          r_settle_cnt;
    logic                     r_ack;
    logic [CNT_W-1:0]         r_count;
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    logic w_req_s;
    logic w_pending;
    logic w_pop;
    logic w_space;
    logic w_settle_done;
    logic w_capture;
    logic w_settle_load;
    logic w_settle_dec;

    click_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (req),
        .o_sync  (w_req_s)
    );

    assign w_pending = w_req_s ^ r_ack;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_space   = (r_count < FULL_CNT) || w_pop;
    // Settling ends on the edge the counter steps from 1 to 0.
    assign w_settle_done = (r_settle_cnt <= SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_pending) begin
                    if (SKIP_SETTLE) begin
                        w_state_next = w_space ? StIdle : StWaitSpace;
                    end else begin
                        w_state_next = StSettle;
                    end
                end
            end
            StSettle: begin
                if (w_settle_done) begin
                    w_state_next = w_space ? StIdle : StWaitSpace;
                end
            end
            StWaitSpace: begin
                if (w_space) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_capture     = 1'b0;
        w_settle_load = 1'b0;
        w_settle_dec  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_settle_load = w_pending && !SKIP_SETTLE;
                w_capture     = w_pending && SKIP_SETTLE && w_space;
            end
            StSettle: begin
                w_settle_dec = (r_settle_cnt != '0);
                w_capture    = w_settle_done && w_space;
            end
            StWaitSpace: begin
                w_capture = w_space;
            end
            default: begin
                w_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if (w_settle_load) begin
            r_settle_cnt <= SETTLE_LOAD;
        end else if (w_settle_dec) begin
            r_settle_cnt <= r_settle_cnt - SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack <= 1'b0;
        end else if (w_capture) begin
            r_ack <= ~r_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_capture) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    assign ack      = r_ack;
    assign out_data = r_mem[r_rptr];
    assign count    = r_count;

endmodule

// File: tb/tb_click_sink.sv
// Directed and randomized checks of click_sink against a queue-based token model.
module tb_click_sink;

    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned SETTLE  = 1;
    localparam int unsigned SYNC2   = 3;
    localparam int unsigned SETTLE2 = 0;
    localparam int          LAT     = SYNC + SETTLE + 1;
    localparam int          NTOK2   = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [DW-1:0] data_in;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    count;

    logic          req2;
    logic [DW-1:0] data_in2;
    logic          ack2;
    logic          out_valid2;
    logic          out_ready2;
    logic [DW-1:0] out_data2;
    logic [2:0]    count2;

    int n_cmp = 0;
    int n_err = 0;
    int n_tok = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp2_q[$];

    always #5 clk = ~clk;

    click_sink #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    click_sink #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .SYNC_STAGES   (SYNC2),
        .SETTLE_CYCLES (SETTLE2)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req2),
        .data_in   (data_in2),
        .ack       (ack2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .count     (count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        logic prev;
        prev = ack;
        lat  = 0;
        while (lat < 30) begin
            step();
            lat++;
            if (ack !== prev) break;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, output int lat);
        data_in = d;
        req     = ~req;
        exp_q.push_back(d);
        n_tok++;
        wait_ack(lat);
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int            lat;
        logic          prev;
        logic          want_ack;
        logic [DW-1:0] head;
        logic [DW-1:0] d;
        logic          popping;
        int            issued;
        int            acks;
        int            pops;
        logic          outstanding;
        logic          prev2;

        reset      = 1'b1;
        req        = 1'b0;
        data_in    = '0;
        out_ready  = 1'b0;
        req2       = 1'b0;
        data_in2   = '0;
        out_ready2 = 1'b0;
        step();
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        step();

        // Single token latency and first-word fall-through.
        send(8'hA5, lat);
        check("lat_first", lat, LAT);
        check("ack_first", 32'(ack), 32'd1);
        check("valid_first", 32'(out_valid), 32'd1);
        check("count_first", 32'(count), 32'd1);
        pop_check("data_first");
        check("count_drained", 32'(count), 32'd0);

        // Fill to full, then a fifth token must wait for space.
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), lat);
            check("lat_fill", lat, LAT);
        end
        check("count_full", 32'(count), 32'd4);
        data_in = 8'h05;
        req     = ~req;
        exp_q.push_back(8'h05);
        n_tok++;
        prev = ack;
        repeat (10) step();
        check("wait_ack_hold", 32'(ack), 32'(prev));
        check("wait_count", 32'(count), 32'd4);

        // Pop while full and waiting: push and pop share the edge.
        head      = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        want_ack  = ~prev;
        check("wait_ack_toggle", 32'(ack), 32'(want_ack));
        check("wait_count_same", 32'(count), 32'd4);
        check("wait_head", 32'(head), 32'(exp_q.pop_front()));
        for (int i = 0; i < 4; i++) pop_check("drain");
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Capture into an empty FIFO with the consumer ready: no bypass.
        out_ready = 1'b1;
        send(8'h3C, lat);
        check("empty_lat", lat, LAT);
        check("empty_valid", 32'(out_valid), 32'd1);
        check("empty_count", 32'(count), 32'd1);
        check("empty_data", 32'(out_data), 32'(exp_q.pop_front()));
        step();
        out_ready = 1'b0;
        check("empty_popped", 32'(count), 32'd0);
        check("ack_parity", 32'(ack), 32'(n_tok % 2));

        // Reset from ack=1, then reset again mid-settle with tokens stored.
        reset = 1'b1;
        req   = 1'b0;
        step();
        reset = 1'b0;
        check("rst2_ack", 32'(ack), 32'd0);
        check("rst2_count", 32'(count), 32'd0);
        exp_q.delete();
        send(8'h11, lat);
        send(8'h22, lat);
        check("pre_rst_count", 32'(count), 32'd2);
        data_in = 8'h33;
        req     = 1'b1;
        repeat (SYNC + 1) step();
        check("settle_ack_hold", 32'(ack), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h33);
        wait_ack(lat);
        check("post_rst_lat", lat, LAT);
        check("post_rst_count", 32'(count), 32'd1);
        pop_check("post_rst_data");

        // Randomized stream on the second instance.
        issued      = 0;
        acks        = 0;
        pops        = 0;
        outstanding = 1'b0;
        prev2       = ack2;
        for (int cyc = 0; cyc < 20000 && pops < NTOK2; cyc++) begin
            if (!outstanding && issued < NTOK2) begin
                d        = DW'($urandom);
                data_in2 = d;
                req2     = ~req2;
                exp2_q.push_back(d);
                outstanding = 1'b1;
                issued++;
            end
            out_ready2 = 1'($urandom_range(0, 1));
            popping    = out_valid2 && out_ready2;
            head       = out_data2;
            step();
            if (ack2 !== prev2) begin
                acks++;
                prev2       = ack2;
                outstanding = 1'b0;
            end
            if (popping) begin
                pops++;
                d = (exp2_q.size() > 0) ? exp2_q.pop_front() : 8'hxx;
                check("stream_data", 32'(head), 32'(d));
            end
        end
        out_ready2 = 1'b0;
        check("stream_acks", acks, NTOK2);
        check("stream_pops", pops, NTOK2);
        check("stream_left", exp2_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
